// File: rtl/keypress_encoder_if.sv
// Command/keycode bus between a move-command producer and keypress_encoder.
// master = command producer side, slave = encoder side.
interface keypress_encoder_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]       cmd;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       keycode;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;
    logic             cmd_err;

    modport master (
        output cmd, cmd_valid,
        input  cmd_ready, keycode, busy, fifo_level, cmd_err
    );

    modport slave (
        input  cmd, cmd_valid,
        output cmd_ready, keycode, busy, fifo_level, cmd_err
    );
endinterface

// File: rtl/keypress_encoder.sv
// keypress_encoder: queues 4-bit move commands and plays each one out as a
// timed keycode press followed by a 0x00 release.
// Optional feature macro: KEYPRESS_ENCODER_DROP_MERGE_EN -- back-to-back S
// (drop) commands extend one continuous press instead of re-pressing.
module keypress_encoder #(
    parameter int unsigned PRESS_CYCLES   = 4,
    parameter int unsigned RELEASE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    keypress_encoder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES - 1);
`ifdef KEYPRESS_ENCODER_DROP_MERGE_EN
    localparam logic [7:0] KEY_S = 8'h16;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_RELEASE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       keycode_q, keycode_d;
    logic             cmd_err_q, cmd_err_d;
    logic             busy_q, busy_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [3:0]       mem_q [FIFO_DEPTH];

    logic             push;
    logic             pop;
    logic             fifo_nonempty;
    logic [3:0]       head_cmd;
    logic [7:0]       head_key;
    logic             head_ok;

    // Decode the FIFO head into its keycode and validity.
    always_comb begin
        head_cmd = mem_q[rd_ptr_q];
        head_key = 8'h00;
        head_ok  = 1'b1;
        case (head_cmd)
            4'd1:    head_key = 8'h1A;
            4'd2:    head_key = 8'h04;
            4'd3:    head_key = 8'h16;
            4'd4:    head_key = 8'h07;
            4'd5:    head_key = 8'h15;
            default: head_ok  = 1'b0;
        endcase
    end

    // Next-state logic for the press/release sequencer and the command FIFO.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        keycode_d     = keycode_q;
        cmd_err_d     = 1'b0;
        pop           = 1'b0;
        fifo_nonempty = (level_q != '0);
        push          = bus.cmd_valid && cmd_ready_q;

        case (state_q)
            ST_IDLE: begin
                keycode_d = 8'h00;
                if (fifo_nonempty) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        keycode_d = head_key;
                        cnt_d     = PRESS_LOAD;
                        state_d   = ST_PRESS;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_PRESS: begin
                if (cnt_q == '0) begin
`ifdef KEYPRESS_ENCODER_DROP_MERGE_EN
                    // A queued drop extends the held S key without a release.
                    if (keycode_q == KEY_S && fifo_nonempty && head_cmd == 4'd3) begin
                        pop   = 1'b1;
                        cnt_d = PRESS_LOAD;
                    end else begin
                        keycode_d = 8'h00;
                        cnt_d     = RELEASE_LOAD;
                        state_d   = ST_RELEASE;
                    end
`else
                    keycode_d = 8'h00;
                    cnt_d     = RELEASE_LOAD;
                    state_d   = ST_RELEASE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                keycode_d = 8'h00;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                keycode_d = 8'h00;
            end
        endcase

        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
        cmd_ready_d = (level_d != LVL_W'(FIFO_DEPTH));
        busy_d      = (state_d != ST_IDLE) || (level_d != '0);
    end

    // State and registered outputs; reset drops keycode and discards the queue.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            keycode_q   <= 8'h00;
            cmd_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            keycode_q   <= keycode_d;
            cmd_err_q   <= cmd_err_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    // FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.cmd;
        end
    end

    assign bus.keycode    = keycode_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.busy       = busy_q;
    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.fifo_level = level_q;
endmodule

// File: doc/keypress_encoder.md
Name: keypress_encoder

Overview:
- Transmit side of the keyboard keycode interface: turns abstract 4-bit move commands into timed 8-bit USB-style keycode press/release sequences on a `keycode` bus.
- Each sequence is a press followed by release (0x00). The keypress-detection logic downstream registers exactly one event per command.
- Drives the game input path from a non-keyboard source (demo/autoplay, scripted test, AI player) in place of the USB keyboard.
- Commands are buffered in a small FIFO so a producer can queue bursts.

Parameters:
- PRESS_CYCLES, 4: cycles keycode is held at the key value; legal range 2..255.
- RELEASE_CYCLES, 4: cycles keycode is held at 0x00 after each press; legal range 2..255.
- FIFO_DEPTH, 4: command queue entries; power of 2, 2..16.

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- cmd  in  4  command: 1=W(rotate) 2=A(left) 3=S(drop) 4=D(right) 5=R(restart); others invalid
- cmd_valid  in  1  producer offers cmd this cycle
- cmd_ready  out  1  FIFO can accept; transfer when cmd_valid && cmd_ready
- keycode  out  8  emitted keycode (registered)
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current queued entries
- cmd_err  out  1  one-cycle pulse when an invalid command is dequeued

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, keycode=8'h00, cmd_ready=1, busy=0, fifo_level=0, cmd_err=0. Assert mid-press drops keycode to 0x00 immediately; queued commands discarded.
- Keycode map: 1->8'h1A, 2->8'h04, 3->8'h16, 4->8'h07, 5->8'h15.
- FIFO:
  - cmd_ready = (fifo_level != FIFO_DEPTH).
  - Push on handshake; pop only from IDLE.
  - Simultaneous push and pop allowed (level unchanged); no push when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - No bypass: a command accepted in cycle t is poppable at t+1.
- FSM states: IDLE, PRESS, RELEASE. Counter width 8 bits.
  - IDLE, FIFO empty: keycode=0x00, stay.
  - IDLE, FIFO non-empty, valid head: pop, load keycode with mapped value, cnt=PRESS_CYCLES-1, -> PRESS.
  - IDLE, invalid head: pop, pulse cmd_err next cycle, keycode stays 0x00, stay IDLE.
  - PRESS: keycode held; cnt==0 -> keycode=0x00, cnt=RELEASE_CYCLES-1, -> RELEASE; else cnt--.
  - RELEASE: keycode=0x00; cnt==0 -> IDLE; else cnt--.
- Timing:
  - keycode equals the key value for exactly PRESS_CYCLES cycles.
  - Minimum 0x00 gap between back-to-back presses: RELEASE_CYCLES+1 cycles, because IDLE consumes one cycle.
  - Handshake at t -> key on keycode from t+2.
- Gap guarantee: consecutive identical commands always yield distinct presses separated by ≥ 1 cycle of 0x00, so the downstream hold state returns to its idle state each time.
- busy deasserts the cycle after RELEASE->IDLE with FIFO empty.

Optional Feature:
- Macro: KEYPRESS_ENCODER_DROP_MERGE_EN.
- Defined: in PRESS with key S (8'h16), if cnt==0 and the FIFO head is cmd 3, pop it and reload cnt=PRESS_CYCLES-1 without a release. Consecutive S commands become one continuous press of N*PRESS_CYCLES, so the soft-drop hold behaves like a held key.
- Undefined: every command, including S, gets its own press/release pair.

Test Plan:
- Reset then push cmd=2 at cycle 0 (PRESS=4, RELEASE=4) -> keycode 0x04 for cycles 2..5, 0x00 for 6..9, busy low from cycle 10, cmd_err never set.
- Push 1,5,4 back-to-back -> keycode sequence 0x1A×4, 0x00×5, 0x15×4, 0x00×5, 0x07×4, 0x00; fifo_level peaks at 2.
- Push FIFO_DEPTH+2 commands with cmd_valid held continuously -> cmd_ready low when level=4, all commands emitted in order, none lost or duplicated.
- Push cmd=9 then cmd=3 -> cmd_err one-cycle pulse, keycode stays 0x00 for the invalid entry, then 0x16×4.
- Assert Reset low mid-PRESS of 0x07 with 2 queued -> keycode 0x00 asynchronously, fifo_level=0, cmd_ready=1; after release nothing emitted.
- Push 3,3,3: without the macro -> three 0x16×4 bursts separated by 5×0x00; with KEYPRESS_ENCODER_DROP_MERGE_EN -> single 0x16×12 then 0x00.
